alarm_controller: RTL and testbench

//  Alarm stage downstream of the minute/hour time counters. Consumes current time + minute tick.

---
 rtl/alarm_controller_pkg.sv | 21 ++
 rtl/alarm_controller_if.sv | 31 +++
 rtl/alarm_controller_blink_gen.sv | 42 ++++
 rtl/alarm_controller.sv | 110 +++++++++++
 tb/tb_alarm_controller.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alarm_controller_pkg.sv
// Shared types and constants for the clock/alarm blocks.
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SET     = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } alarm_state_t;

  localparam int HOUR_W = 6;
  localparam int MIN_W  = 7;

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [6:0] SEG_ALL = 7'b0000000;

  function automatic logic [6:0] wrap_inc(input logic [6:0] value, input logic [6:0] max_value);
    return (value >= max_value) ? 7'd0 : value + 7'd1;
  endfunction

endpackage

// File: rtl/alarm_controller_if.sv
// Time/button inputs and alarm outputs exchanged with the alarm stage.
interface alarm_controller_if;
  import clock_pkg::*;

  logic [HOUR_W-1:0] curr_hours;
  logic [MIN_W-1:0]  curr_minutes;
  logic              minute_tick;
  logic              alarm_enable;
  logic              btn_set;
  logic              btn_inc_hour;
  logic              btn_inc_min;
  logic              btn_stop;
  logic              btn_snooze;
  logic [HOUR_W-1:0] alarm_hours;
  logic [MIN_W-1:0]  alarm_minutes;
  logic              alarm_active;
  logic [6:0]        alarm_signal;

  modport master (
    output curr_hours, curr_minutes, minute_tick, alarm_enable,
    output btn_set, btn_inc_hour, btn_inc_min, btn_stop, btn_snooze,
    input  alarm_hours, alarm_minutes, alarm_active, alarm_signal
  );

  modport slave (
    input  curr_hours, curr_minutes, minute_tick, alarm_enable,
    input  btn_set, btn_inc_hour, btn_inc_min, btn_stop, btn_snooze,
    output alarm_hours, alarm_minutes, alarm_active, alarm_signal
  );

endinterface

// File: rtl/alarm_controller_blink_gen.sv
// Blink phase generator: phase toggles every DIV clocks, held at 0 while clr_i is high.
module blink_gen #(
  parameter int DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic phase_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (clr_i) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == CW'(DIV - 1)) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/alarm_controller.sv
// Alarm stage: settable alarm time, match edge detect, ring/snooze/timeout FSM and blink output.
import clock_pkg::*;

module alarm_controller #(
  parameter int DEFAULT_HOUR   = 7,
  parameter int DEFAULT_MIN    = 0,
  parameter int RING_MINUTES   = 5,
  parameter int SNOOZE_MINUTES = 5,
  parameter int BLINK_DIV      = 25_000_000
) (
  input logic              clk,
  input logic              rst,
  alarm_controller_if.slave bus
);

  localparam int RW = (RING_MINUTES > 0)   ? $clog2(RING_MINUTES + 1)   : 1;
  localparam int SW = (SNOOZE_MINUTES > 0) ? $clog2(SNOOZE_MINUTES + 1) : 1;

  alarm_state_t      state_q, state_d;
  logic [HOUR_W-1:0] hour_q, hour_d;
  logic [MIN_W-1:0]  min_q, min_d;
  logic [RW-1:0]     ring_cnt_q, ring_cnt_d;
  logic [SW-1:0]     snooze_cnt_q, snooze_cnt_d;
  logic              match, match_prev_q;
  logic              alarm_active_q;
  logic              blink_phase;

  assign match = (bus.curr_hours == hour_q) && (bus.curr_minutes == min_q);

  always_comb begin
    state_d      = state_q;
    hour_d       = hour_q;
    min_d        = min_q;
    ring_cnt_d   = (state_q == RINGING) ? ring_cnt_q : '0;
    snooze_cnt_d = (state_q == SNOOZE) ? snooze_cnt_q : '0;
    unique case (state_q)
      IDLE: begin
        if (bus.btn_set)
          state_d = SET;
        else if (bus.alarm_enable && match && !match_prev_q)
          state_d = RINGING;
      end
      SET: begin
        if (bus.btn_inc_hour)
          hour_d = HOUR_W'(wrap_inc(7'(hour_q), 7'd23));
        if (bus.btn_inc_min)
          min_d = wrap_inc(min_q, 7'd59);
        if (bus.btn_set)
          state_d = IDLE;
      end
      RINGING: begin
        if (!bus.alarm_enable || bus.btn_stop) begin
          state_d = IDLE;
        end else if (bus.btn_snooze) begin
          state_d = SNOOZE;
        end else if (bus.minute_tick) begin
          if (ring_cnt_q >= RW'(RING_MINUTES - 1))
            state_d = IDLE;
          else
            ring_cnt_d = ring_cnt_q + 1'b1;
        end
      end
      SNOOZE: begin
        if (!bus.alarm_enable || bus.btn_stop) begin
          state_d = IDLE;
        end else if (bus.minute_tick) begin
          if (snooze_cnt_q >= SW'(SNOOZE_MINUTES - 1))
            state_d = RINGING;
          else
            snooze_cnt_d = snooze_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      hour_q         <= HOUR_W'(DEFAULT_HOUR);
      min_q          <= MIN_W'(DEFAULT_MIN);
      ring_cnt_q     <= '0;
      snooze_cnt_q   <= '0;
      match_prev_q   <= 1'b0;
      alarm_active_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      hour_q         <= hour_d;
      min_q          <= min_d;
      ring_cnt_q     <= ring_cnt_d;
      snooze_cnt_q   <= snooze_cnt_d;
      match_prev_q   <= match;
      alarm_active_q <= (state_d == RINGING);
    end
  end

  // Held clear outside RINGING so every entry starts lit with a fresh half-period.
  blink_gen #(.DIV(BLINK_DIV)) u_blink (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (state_q != RINGING),
    .phase_o (blink_phase)
  );

  assign bus.alarm_hours   = hour_q;
  assign bus.alarm_minutes = min_q;
  assign bus.alarm_active  = alarm_active_q;
  assign bus.alarm_signal  = (state_q == RINGING && !blink_phase) ? SEG_ALL : SEG_OFF;

endmodule

// File: tb/tb_alarm_controller.sv
// Scoreboard bench for alarm_controller: directed scenarios then random stimulus against a reference model.
module tb_alarm_controller;

  localparam int RING   = 2;
  localparam int SNOOZE = 3;
  localparam int DIV    = 4;

  localparam int M_IDLE   = 0;
  localparam int M_SET    = 1;
  localparam int M_RING   = 2;
  localparam int M_SNOOZE = 3;

  typedef struct {
    int active;
    int signal;
    int hours;
    int minutes;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alarm_controller_if ifc ();

  alarm_controller #(
    .DEFAULT_HOUR   (7),
    .DEFAULT_MIN    (0),
    .RING_MINUTES   (RING),
    .SNOOZE_MINUTES (SNOOZE),
    .BLINK_DIV      (DIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  exp_t expq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state
  int m_mode = M_IDLE;
  int m_h = 7, m_m = 0;
  int m_prev = 0;
  int m_ticks = 0, m_sticks = 0;
  int m_start = 0;
  int cyc = 0;

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      chk("alarm_active",  int'(ifc.alarm_active),  e.active);
      chk("alarm_signal",  int'(ifc.alarm_signal),  e.signal);
      chk("alarm_hours",   int'(ifc.alarm_hours),   e.hours);
      chk("alarm_minutes", int'(ifc.alarm_minutes), e.minutes);
    end
  end

  function automatic void enter_ring();
    m_mode  = M_RING;
    m_ticks = 0;
    m_start = cyc;
  endfunction

  // Advance the model by one clock edge with the currently driven inputs, then let the DUT take the edge.
  task automatic step();
    exp_t e;
    int match;
    match = (int'(ifc.curr_hours) == m_h) && (int'(ifc.curr_minutes) == m_m);
    cyc++;
    if (rst) begin
      m_mode = M_IDLE; m_h = 7; m_m = 0; m_prev = 0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (ifc.btn_set) m_mode = M_SET;
          else if (ifc.alarm_enable && match && !m_prev) enter_ring();
        end
        M_SET: begin
          if (ifc.btn_inc_hour) m_h = (m_h + 1) % 24;
          if (ifc.btn_inc_min)  m_m = (m_m + 1) % 60;
          if (ifc.btn_set) m_mode = M_IDLE;
        end
        M_RING: begin
          if (!ifc.alarm_enable || ifc.btn_stop) m_mode = M_IDLE;
          else if (ifc.btn_snooze) begin m_mode = M_SNOOZE; m_sticks = 0; end
          else if (ifc.minute_tick) begin
            m_ticks++;
            if (m_ticks >= RING) m_mode = M_IDLE;
          end
        end
        default: begin
          if (!ifc.alarm_enable || ifc.btn_stop) m_mode = M_IDLE;
          else if (ifc.minute_tick) begin
            m_sticks++;
            if (m_sticks >= SNOOZE) enter_ring();
          end
        end
      endcase
      m_prev = match;
    end
    e.active  = (m_mode == M_RING);
    e.signal  = (m_mode == M_RING && (((cyc - m_start) / DIV) % 2 == 0)) ? 0 : 7'h7f;
    e.hours   = m_h;
    e.minutes = m_m;
    @(posedge clk);
    expq.push_back(e);
    #1;
    ifc.minute_tick  = 1'b0;
    ifc.btn_set      = 1'b0;
    ifc.btn_inc_hour = 1'b0;
    ifc.btn_inc_min  = 1'b0;
    ifc.btn_stop     = 1'b0;
    ifc.btn_snooze   = 1'b0;
    rst              = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_time(input int h, input int m);
    ifc.curr_hours   = 6'(h);
    ifc.curr_minutes = 7'(m);
  endtask

  task automatic do_reset();
    rst = 1'b1; step();
    rst = 1'b1; step();
  endtask

  task automatic start_ring();
    set_time(6, 59); step();
    set_time(7, 0);  step();
  endtask

  task automatic tick_after(input int gap);
    idle(gap);
    ifc.minute_tick = 1'b1; step();
  endtask

  initial begin
    rst = 1'b1;
    ifc.alarm_enable = 1'b1;
    ifc.minute_tick  = 1'b0;
    ifc.btn_set      = 1'b0;
    ifc.btn_inc_hour = 1'b0;
    ifc.btn_inc_min  = 1'b0;
    ifc.btn_stop     = 1'b0;
    ifc.btn_snooze   = 1'b0;
    set_time(12, 30);
    do_reset();
    idle(2);

    // Set alarm from 07:00 to 00:00 via both wraps
    ifc.btn_set = 1'b1; step();
    for (int i = 0; i < 17; i++) begin ifc.btn_inc_hour = 1'b1; step(); end
    for (int i = 0; i < 60; i++) begin ifc.btn_inc_min = 1'b1; step(); end
    ifc.btn_set = 1'b1; step();
    idle(3);
    do_reset();

    // Trigger, blink, stop, no re-ring while 07:00 persists
    start_ring();
    idle(10);
    ifc.btn_stop = 1'b1; step();
    idle(8);

    // Timeout after RING minute ticks
    start_ring();
    tick_after(3);
    tick_after(2);
    idle(4);

    // Snooze, re-ring, stop+snooze same cycle
    start_ring();
    idle(2);
    ifc.btn_snooze = 1'b1; step();
    tick_after(2); tick_after(1); tick_after(2);
    idle(6);
    ifc.btn_stop = 1'b1; ifc.btn_snooze = 1'b1; step();
    idle(4);

    // Disable during SNOOZE
    start_ring();
    ifc.btn_snooze = 1'b1; step();
    idle(2);
    ifc.alarm_enable = 1'b0; step();
    ifc.alarm_enable = 1'b1; idle(3);

    // Alarm time reached while in SET must not ring
    set_time(6, 59);
    ifc.btn_set = 1'b1; step();
    set_time(7, 0); idle(3);
    ifc.btn_set = 1'b1; step();
    idle(4);

    // Reset mid-RINGING
    start_ring();
    idle(2);
    rst = 1'b1; step();
    idle(3);

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 2) == 0) set_time(m_h, m_m);
        else set_time($urandom_range(0, 23), $urandom_range(0, 59));
      end
      rst              = ($urandom_range(0, 399) == 0);
      ifc.alarm_enable = ($urandom_range(0, 24) != 0);
      ifc.minute_tick  = ($urandom_range(0, 4) == 0);
      ifc.btn_set      = ($urandom_range(0, 49) == 0);
      ifc.btn_inc_hour = ($urandom_range(0, 3) == 0);
      ifc.btn_inc_min  = ($urandom_range(0, 3) == 0);
      ifc.btn_stop     = ($urandom_range(0, 39) == 0);
      ifc.btn_snooze   = ($urandom_range(0, 19) == 0);
      step();
    end

    for (int i = 0; i < 10 && expq.size() > 0; i++) @(negedge clk);
    #2;
    n_checks++;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", expq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
